// File: rtl/ham_pkg.sv
// ham_pkg: constants and helpers for the Hamming(17,12) code.
// Codeword bit i carries Hamming position i+1. Parity bits sit at the
// power-of-two positions 1, 2, 4, 8 and 16. Data bits fill the remaining
// positions (3, 5, 6, 7, 9..15, 17), with the info LSB at the lowest position.
// The position-to-index mapping is shared with the encoder.
package ham_pkg;

  localparam int INFO_W  = 12;
  localparam int CW_W    = 17;
  localparam int SYN_W   = 5;
  localparam int MAX_POS = 17;

  // A position carries data when it is inside the codeword and is not a power of two.
  function automatic logic is_data_pos(input logic [SYN_W-1:0] pos);
    return (pos != '0) && (pos <= SYN_W'(MAX_POS)) &&
           ((pos & (pos - SYN_W'(1))) != '0);
  endfunction

  // Info-bit index carried at a data position. Returns 0 for non-data positions.
  function automatic logic [3:0] pos_to_data_idx(input logic [SYN_W-1:0] pos);
    logic [3:0] idx;
    case (pos)
      5'd3:    idx = 4'd0;
      5'd5:    idx = 4'd1;
      5'd6:    idx = 4'd2;
      5'd7:    idx = 4'd3;
      5'd9:    idx = 4'd4;
      5'd10:   idx = 4'd5;
      5'd11:   idx = 4'd6;
      5'd12:   idx = 4'd7;
      5'd13:   idx = 4'd8;
      5'd14:   idx = 4'd9;
      5'd15:   idx = 4'd10;
      5'd17:   idx = 4'd11;
      default: idx = 4'd0;
    endcase
    return idx;
  endfunction

  // Collect the info bits from the data positions of a codeword.
  function automatic logic [INFO_W-1:0] extract_info(input logic [CW_W-1:0] cw);
    logic [INFO_W-1:0] info;
    info = '0;
    for (int p = 1; p <= MAX_POS; p++) begin
      if (is_data_pos(SYN_W'(p)))
        info[pos_to_data_idx(SYN_W'(p))] = cw[p-1];
    end
    return info;
  endfunction

endpackage

// File: rtl/ham_syndrome.sv
// ham_syndrome: combinational syndrome computation for a Hamming(17,12) codeword.
// Syndrome bit k is the XOR of every set codeword position whose index has bit k set.
// That equals the XOR of the position numbers of all set bits.
// Ports:
//   codeword  in  17  received codeword (bit i = position i+1)
//   syndrome  out  5  0 = clean, 1..17 = single-bit error position, 18..31 = uncorrectable
module ham_syndrome
  import ham_pkg::*;
(
  input  logic [CW_W-1:0]  codeword,
  output logic [SYN_W-1:0] syndrome
);

  always_comb begin
    syndrome = '0;
    for (int p = 1; p <= MAX_POS; p++) begin
      if (codeword[p-1])
        syndrome = syndrome ^ SYN_W'(p);
    end
  end

endmodule

// File: rtl/ham_dec_pipe.sv
// ham_dec_pipe: two-stage valid/ready Hamming(17,12) decoder.
// Stage 1 holds the received codeword; the syndrome is derived from it.
// Stage 2 is the output register. It holds the corrected info, the raw
// syndrome and the status flags.
// The two error counters count words delivered with each flag and saturate
// at all-ones.
// Ports:
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     input handshake
//   in_codeword    [17]   received codeword
//   out_valid/out_ready   output handshake (out_valid is registered)
//   out_info       [12]   corrected info bits
//   out_corrected         single-bit error corrected
//   out_uncorr            syndrome 18..31; out_info carries the uncorrected data
//   out_syndrome   [5]    raw syndrome
//   cnt_clr               synchronous clear of both counters (wins over increment)
//   corr_cnt, uncorr_cnt  [CNT_W] saturating counts of delivered flagged words
module ham_dec_pipe
  import ham_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   in_codeword,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INFO_W-1:0] out_info,
  output logic              out_corrected,
  output logic              out_uncorr,
  output logic [SYN_W-1:0]  out_syndrome,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  logic              s1_valid;
  logic [CW_W-1:0]   s1_cw;
  logic [SYN_W-1:0]  s1_syn;
  logic              s1_advance;
  logic              s2_advance;
  logic [CW_W-1:0]   flip_mask;
  logic [CW_W-1:0]   fixed_cw;
  logic [INFO_W-1:0] fixed_info;
  logic              syn_corr;
  logic              syn_uncorr;
  logic              out_hs;

  ham_syndrome u_syndrome (
    .codeword (s1_cw),
    .syndrome (s1_syn)
  );

  // The output register frees up when it is empty or its word is being taken.
  // Stage 1 moves whenever stage 2 can load, so an empty stage 1 simply loads a bubble.
  assign s2_advance = out_ready | ~out_valid;
  assign s1_advance = s2_advance;
  assign in_ready   = ~s1_valid | s1_advance;
  assign out_hs     = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_cw    <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid)
        s1_cw <= in_codeword;
    end
  end

  // Syndromes 1..17 name the erroneous position; anything above is not a valid position.
  always_comb begin
    flip_mask  = '0;
    syn_corr   = 1'b0;
    syn_uncorr = 1'b0;
    if (s1_syn != '0) begin
      if (s1_syn <= SYN_W'(MAX_POS)) begin
        flip_mask = CW_W'(1) << (s1_syn - SYN_W'(1));
        syn_corr  = 1'b1;
      end else begin
        syn_uncorr = 1'b1;
      end
    end
  end

  assign fixed_cw   = s1_cw ^ flip_mask;
  assign fixed_info = extract_info(fixed_cw);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid     <= 1'b0;
      out_info      <= '0;
      out_syndrome  <= '0;
      out_corrected <= 1'b0;
      out_uncorr    <= 1'b0;
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_info      <= fixed_info;
        out_syndrome  <= s1_syn;
        out_corrected <= syn_corr;
        out_uncorr    <= syn_uncorr;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (cnt_clr) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else begin
      if (out_hs && out_corrected && (corr_cnt != '1))
        corr_cnt <= corr_cnt + CNT_W'(1);
      if (out_hs && out_uncorr && (uncorr_cnt != '1))
        uncorr_cnt <= uncorr_cnt + CNT_W'(1);
    end
  end

endmodule
